// File: rtl/qpsk_pkg.sv
// Shared types and defaults for the QPSK transmit path.
`timescale 1ns/1ps
package qpsk_pkg;

    localparam int DEFAULT_SPS        = 16;
    localparam int DEFAULT_FIFO_DEPTH = 4;

    typedef struct packed {
        logic i;
        logic q;
    } dibit_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/qpsk_pair_fifo.sv
// Circular dibit FIFO; DEPTH must be a power of two so the pointers wrap naturally.
`timescale 1ns/1ps
module qpsk_pair_fifo
    import qpsk_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  dibit_t                   din,
    input  logic                     pop,
    output dibit_t                   dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   fill_level
);

    localparam int AW = $clog2(DEPTH);

    dibit_t        mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign full       = (count_q == (AW+1)'(DEPTH));
    assign empty      = (count_q == '0);
    assign fill_level = count_q;
    assign dout       = mem_q[rd_ptr_q];
    assign do_push    = push & ~full;
    assign do_pop     = pop & ~empty;

    // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/qpsk_bit_splitter.sv
// Pairs a serial bit stream into (I,Q) dibits and presents each for SPS cycles.
`timescale 1ns/1ps
module qpsk_bit_splitter
    import qpsk_pkg::*;
#(
    parameter int SPS        = DEFAULT_SPS,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          bit_in,
    input  logic                          bit_valid,
    output logic                          bit_ready,
    input  logic                          enable,
    input  logic                          clr_underrun,
    output logic                          Ichannel,
    output logic                          Qchannel,
    output logic                          sym_start,
    output logic                          busy,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level
);

    localparam int CNT_W = $clog2(SPS);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               half_held_q, half_held_d;
    logic               i_bit_q, i_bit_d;
    dibit_t             out_q, out_d;
    logic               sym_start_q, sym_start_d;
    logic               underrun_q, underrun_d;

    logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
    dibit_t             push_data, pop_data;
    logic               bit_accept;
    logic               last_cycle;

    // Ready looks only at registered state, never at a same-cycle pop.
    assign bit_ready  = ~(half_held_q & fifo_full);
    assign bit_accept = bit_valid & bit_ready;
    assign push_data  = '{i: i_bit_q, q: bit_in};
    assign last_cycle = (cnt_q == CNT_W'(SPS - 1));

    qpsk_pair_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (fifo_push),
        .din        (push_data),
        .pop        (fifo_pop),
        .dout       (pop_data),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .fill_level (fill_level)
    );

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        half_held_d = half_held_q;
        i_bit_d     = i_bit_q;
        fifo_push   = 1'b0;
        if (bit_accept) begin
            if (half_held_q) begin
                fifo_push   = 1'b1;
                half_held_d = 1'b0;
            end else begin
                i_bit_d     = bit_in;
                half_held_d = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        sym_start_d = 1'b0;
        underrun_d  = underrun_q & ~clr_underrun;
        fifo_pop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && !fifo_empty) begin
                    fifo_pop    = 1'b1;
                    out_d       = pop_data;
                    sym_start_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = RUN;
                end
            end
            RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (last_cycle) begin
                    cnt_d = '0;
                    if (enable && !fifo_empty) begin
                        fifo_pop    = 1'b1;
                        out_d       = pop_data;
                        sym_start_d = 1'b1;
                    end else begin
                        // A new underrun beats a simultaneous clear.
                        if (enable) underrun_d = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            half_held_q <= 1'b0;
            i_bit_q     <= 1'b0;
            out_q       <= '0;
            sym_start_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            half_held_q <= half_held_d;
            i_bit_q     <= i_bit_d;
            out_q       <= out_d;
            sym_start_q <= sym_start_d;
            underrun_q  <= underrun_d;
        end
    end

    assign Ichannel  = out_q.i;
    assign Qchannel  = out_q.q;
    assign sym_start = sym_start_q;
    assign busy      = (state_q == RUN);
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_qpsk_bit_splitter.sv
// Directed scenarios for qpsk_bit_splitter with hand-derived expectations.
`timescale 1ns/1ps
module tb_qpsk_bit_splitter;

    localparam int SPS = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       enable = 1'b0;
    logic       clr_underrun = 1'b0;
    logic       bit_ready;
    logic       Ichannel, Qchannel, sym_start, busy, underrun;
    logic [2:0] fill_level;
    logic [4:0] status;

    int pass_cnt  = 0;
    int total_cnt = 0;

    qpsk_bit_splitter #(.SPS(SPS), .FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bit_in       (bit_in),
        .bit_valid    (bit_valid),
        .bit_ready    (bit_ready),
        .enable       (enable),
        .clr_underrun (clr_underrun),
        .Ichannel     (Ichannel),
        .Qchannel     (Qchannel),
        .sym_start    (sym_start),
        .busy         (busy),
        .underrun     (underrun),
        .fill_level   (fill_level)
    );

    always #5 clk = ~clk;

    // {I, Q, sym_start, busy, underrun}
    assign status = {Ichannel, Qchannel, sym_start, busy, underrun};

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset;
        rst_n = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; enable = 1'b0; clr_underrun = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic send_bit(input logic b);
        bit_in = b; bit_valid = 1'b1;
        step();
        bit_valid = 1'b0; bit_in = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        if (status !== 5'b00000) $display("FAIL reset_status: got %b expected %b", status, 5'b00000);
        else pass_cnt++;
        total_cnt++;
        if (fill_level !== 3'd0) $display("FAIL reset_fill: got %0d expected 0", fill_level);
        else pass_cnt++;
        total_cnt++;
        if (bit_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", bit_ready);
        else pass_cnt++;
        total_cnt++;
    endtask

    task automatic test_single_pair;
        do_reset();
        enable = 1'b1;
        send_bit(1'b1);
        send_bit(1'b0);
        if (status !== 5'b00000) $display("FAIL single_not_yet: got %b expected %b", status, 5'b00000);
        else pass_cnt++;
        total_cnt++;
        if (fill_level !== 3'd1) $display("FAIL single_fill: got %0d expected 1", fill_level);
        else pass_cnt++;
        total_cnt++;
        step();
        if (status !== 5'b10110) $display("FAIL single_start: got %b expected %b", status, 5'b10110);
        else pass_cnt++;
        total_cnt++;
        for (int c = 1; c < SPS; c++) begin
            step();
            if (status !== 5'b10010) $display("FAIL single_hold c=%0d: got %b expected %b", c, status, 5'b10010);
            else pass_cnt++;
            total_cnt++;
        end
        step();
        if (status !== 5'b10001) $display("FAIL single_underrun: got %b expected %b", status, 5'b10001);
        else pass_cnt++;
        total_cnt++;
    endtask

    task automatic test_stream;
        logic [7:0] stream = 8'b0001_1110;
        logic [7:0] syms   = 8'b00_01_11_10;
        logic [4:0] exp;
        int         starts = 0;
        int         idx;
        do_reset();
        enable = 1'b1;
        for (int k = 1; k <= 70; k++) begin
            if (k <= 8) begin
                if (bit_ready !== 1'b1) $display("FAIL stream_ready k=%0d: got %b expected 1", k, bit_ready);
                else pass_cnt++;
                total_cnt++;
                bit_valid = 1'b1;
                bit_in    = stream[8-k];
            end else begin
                bit_valid = 1'b0;
            end
            step();
            if (k < 3) begin
                exp = 5'b00000;
            end else if (k < 67) begin
                idx = (k - 3) / SPS;
                exp = {syms[7-2*idx -: 2], ((k - 3) % SPS) == 0, 1'b1, 1'b0};
            end else begin
                exp = 5'b10001;
            end
            if (status !== exp) $display("FAIL stream k=%0d: got %b expected %b", k, status, exp);
            else pass_cnt++;
            total_cnt++;
            if (sym_start === 1'b1) starts++;
        end
        if (starts != 4) $display("FAIL stream_pulses: got %0d expected 4", starts);
        else pass_cnt++;
        total_cnt++;
    endtask

    task automatic test_backpressure;
        logic [8:0] bits = 9'b1_0110_0011;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            if (bit_ready !== 1'b1) $display("FAIL bp_ready_fill i=%0d: got %b expected 1", i, bit_ready);
            else pass_cnt++;
            total_cnt++;
            send_bit(bits[8-i]);
        end
        if (fill_level !== 3'd4) $display("FAIL bp_fill_full: got %0d expected 4", fill_level);
        else pass_cnt++;
        total_cnt++;
        if (bit_ready !== 1'b0) $display("FAIL bp_blocked: got %b expected 0", bit_ready);
        else pass_cnt++;
        total_cnt++;
        // Offer a Q bit while blocked; it must not be taken until ready returns.
        bit_in = 1'b0; bit_valid = 1'b1;
        step(2);
        if (fill_level !== 3'd4) $display("FAIL bp_no_accept: got %0d expected 4", fill_level);
        else pass_cnt++;
        total_cnt++;
        enable = 1'b1;
        step();
        if ({status, fill_level, bit_ready} !== {5'b10110, 3'd3, 1'b1})
            $display("FAIL bp_first_pop: got %b/%0d/%b expected 10110/3/1", status, fill_level, bit_ready);
        else pass_cnt++;
        total_cnt++;
        step();
        bit_valid = 1'b0;
        if ({fill_level, bit_ready} !== {3'd4, 1'b1})
            $display("FAIL bp_q_taken: got %0d/%b expected 4/1", fill_level, bit_ready);
        else pass_cnt++;
        total_cnt++;
        step(14);
        step();
        if ({status, fill_level} !== {5'b11110, 3'd3})
            $display("FAIL bp_second_sym: got %b/%0d expected 11110/3", status, fill_level);
        else pass_cnt++;
        total_cnt++;
    endtask

    task automatic test_enable_drop;
        do_reset();
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        enable = 1'b1;
        step();
        if ({status, fill_level} !== {5'b11110, 3'd1})
            $display("FAIL drop_start: got %b/%0d expected 11110/1", status, fill_level);
        else pass_cnt++;
        total_cnt++;
        step(5);
        enable = 1'b0;
        step(10);
        if (status !== 5'b11010) $display("FAIL drop_last_cycle: got %b expected %b", status, 5'b11010);
        else pass_cnt++;
        total_cnt++;
        step();
        if ({status, fill_level} !== {5'b11000, 3'd1})
            $display("FAIL drop_idle: got %b/%0d expected 11000/1", status, fill_level);
        else pass_cnt++;
        total_cnt++;
        step(3);
        if ({status, fill_level} !== {5'b11000, 3'd1})
            $display("FAIL drop_stays_idle: got %b/%0d expected 11000/1", status, fill_level);
        else pass_cnt++;
        total_cnt++;
    endtask

    task automatic test_reset_mid_symbol;
        do_reset();
        for (int i = 0; i < 9; i++) send_bit(i[0]);
        enable = 1'b1;
        step();
        if ({status, fill_level} !== {5'b01110, 3'd3})
            $display("FAIL rst_mid_start: got %b/%0d expected 01110/3", status, fill_level);
        else pass_cnt++;
        total_cnt++;
        step(8);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        if ({status, fill_level, bit_ready} !== {5'b00000, 3'd0, 1'b1})
            $display("FAIL rst_mid_cleared: got %b/%0d/%b expected 00000/0/1", status, fill_level, bit_ready);
        else pass_cnt++;
        total_cnt++;
        send_bit(1'b1);
        if (fill_level !== 3'd0) $display("FAIL rst_mid_i_held: got %0d expected 0", fill_level);
        else pass_cnt++;
        total_cnt++;
        send_bit(1'b0);
        step();
        if (status !== 5'b10110) $display("FAIL rst_mid_new_pair: got %b expected %b", status, 5'b10110);
        else pass_cnt++;
        total_cnt++;
    endtask

    task automatic test_underrun_clear;
        do_reset();
        enable = 1'b1;
        send_bit(1'b1); send_bit(1'b1);
        step();
        step(SPS - 1);
        step();
        if (status !== 5'b11001) $display("FAIL ur_first: got %b expected %b", status, 5'b11001);
        else pass_cnt++;
        total_cnt++;
        send_bit(1'b0); send_bit(1'b1);
        step();
        if (status !== 5'b01111) $display("FAIL ur_sticky: got %b expected %b", status, 5'b01111);
        else pass_cnt++;
        total_cnt++;
        step(SPS - 1);
        clr_underrun = 1'b1;
        step();
        clr_underrun = 1'b0;
        if (status !== 5'b01001) $display("FAIL ur_set_wins: got %b expected %b", status, 5'b01001);
        else pass_cnt++;
        total_cnt++;
        clr_underrun = 1'b1;
        step();
        clr_underrun = 1'b0;
        if (status !== 5'b01000) $display("FAIL ur_cleared: got %b expected %b", status, 5'b01000);
        else pass_cnt++;
        total_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_pair();
        test_stream();
        test_backpressure();
        test_enable_drop();
        test_reset_mid_symbol();
        test_underrun_clear();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
